// File: rtl/vec_issue_ctrl_if.sv
// Bundle between vec_issue_ctrl and its neighbours: scalar-core handshake, decoder
// controls and the execution-unit issue/done handshake.
interface vec_issue_ctrl_if #(
    parameter int XLEN = 32
);
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] vec_inst;
    logic [XLEN-1:0] inst_q;
    logic            is_vec;
    logic            vl_sel;
    logic            vtype_sel;
    logic            lumop_sel;
    logic            csr_wr_en;
    logic            issue_valid;
    logic            issue_ready;
    logic            exe_done;
    logic            vec_busy;
    logic            illegal;
    logic            timeout;

    modport master (
        input  inst_valid, vec_inst, is_vec, issue_ready, exe_done,
        output inst_ready, inst_q, vl_sel, vtype_sel, lumop_sel, csr_wr_en,
               issue_valid, vec_busy, illegal, timeout
    );

    modport slave (
        output inst_valid, vec_inst, is_vec, issue_ready, exe_done,
        input  inst_ready, inst_q, vl_sel, vtype_sel, lumop_sel, csr_wr_en,
               issue_valid, vec_busy, illegal, timeout
    );
endinterface

// File: rtl/vec_issue_ctrl.sv
// Vector instruction sequencer: accepts one instruction, drives decoder selects,
// writes vl/vtype for vset*, otherwise issues to the execution unit under a watchdog.
module vec_issue_ctrl #(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic             clk,
    input  logic             reset,
    vec_issue_ctrl_if.master bus
);
    localparam int                WDOG_W    = $clog2(TIMEOUT_CYC);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);
    localparam logic [6:0]        OP_VEC    = 7'h57;
    localparam logic [6:0]        OP_VLOAD  = 7'h07;
    localparam logic [6:0]        OP_VSTORE = 7'h27;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        CONFIG,
        ISSUE,
        WAIT
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   inst_q;
    logic [WDOG_W-1:0] wdog;
    logic              inst_ready_q;
    logic              csr_q;
    logic              issue_q;
    logic              busy_q;

    logic              is_conf;
    logic              is_unit_mem;
    logic              active;

    assign is_conf     = (inst_q[6:0] == OP_VEC) && (inst_q[14:12] == 3'b111);
    assign is_unit_mem = ((inst_q[6:0] == OP_VLOAD) || (inst_q[6:0] == OP_VSTORE))
                         && (inst_q[27:26] == 2'b00);
    assign active      = (state != IDLE);

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every branch sees the
        // pre-edge values of state/inst_q/wdog regardless of statement order.
        if (reset) begin
            state        <= IDLE;
            inst_q       <= '0;
            wdog         <= '0;
            inst_ready_q <= 1'b1;
            csr_q        <= 1'b0;
            issue_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.inst_valid) begin
                        inst_q       <= bus.vec_inst;
                        state        <= DECODE;
                        inst_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                DECODE: begin
                    if (!bus.is_vec) begin
                        state        <= IDLE;
                        inst_ready_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end else if (is_conf) begin
                        state <= CONFIG;
                        csr_q <= 1'b1;
                    end else begin
                        state   <= ISSUE;
                        issue_q <= 1'b1;
                    end
                end
                CONFIG: begin
                    state        <= IDLE;
                    csr_q        <= 1'b0;
                    inst_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                end
                ISSUE: begin
                    if (bus.issue_ready) begin
                        issue_q <= 1'b0;
                        if (bus.exe_done) begin
                            state        <= IDLE;
                            inst_ready_q <= 1'b1;
                            busy_q       <= 1'b0;
                        end else begin
                            state <= WAIT;
                            wdog  <= '0;
                        end
                    end
                end
                WAIT: begin
                    // Leaving at WDOG_LAST means the increment below can never wrap.
                    if (bus.exe_done || (wdog == WDOG_LAST)) begin
                        state        <= IDLE;
                        inst_ready_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    inst_ready_q <= 1'b1;
                    csr_q        <= 1'b0;
                    issue_q      <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.inst_q     = inst_q;
    assign bus.inst_ready = inst_ready_q;
    assign bus.vec_busy   = busy_q;
    assign bus.vl_sel     = active && is_conf && (inst_q[31:30] == 2'b11);
    assign bus.vtype_sel  = active && is_conf && (!inst_q[31] || (inst_q[31:30] == 2'b11));
    assign bus.lumop_sel  = active && is_unit_mem;

    // NOTE: strobes are masked by reset so an operation cut off mid-flight can never
    // leak a CSR write, an issue or a timeout in the reset cycle itself.
    assign bus.csr_wr_en   = csr_q && !reset;
    assign bus.issue_valid = issue_q && !reset;

    // illegal/timeout qualify on inputs sampled this cycle, so they fire in the
    // DECODE / final WAIT cycle rather than one cycle late.
    assign bus.illegal = (state == DECODE) && !bus.is_vec && !reset;
    assign bus.timeout = (state == WAIT) && (wdog == WDOG_LAST) && !bus.exe_done && !reset;

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Table-driven bench for vec_issue_ctrl with a scoreboard of expected strobes
// (CSR write, issue handshake, illegal, timeout) plus reset/back-to-back sequences.
module tb_vec_issue_ctrl;
    localparam int TO_CYC = 4;
    localparam int NV     = 12;

    typedef enum logic [2:0] {EV_NONE, EV_CSR, EV_ISSUE, EV_ILLEGAL, EV_TIMEOUT} ev_kind_t;

    typedef struct {
        ev_kind_t    kind;
        logic [31:0] inst;
        logic [2:0]  sel;
    } ev_t;

    typedef struct {
        logic [31:0] inst;
        logic        is_vec;
        int          issue_wait;
        int          exe_delay;
        ev_kind_t    kind;
        logic        vl;
        logic        vtype;
        logic        lumop;
        logic        exp_to;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_fail;
    ev_t  sb[$];
    vec_t vecs[NV];

    vec_issue_ctrl_if #(.XLEN(32)) bus ();

    vec_issue_ctrl #(.XLEN(32), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] sel_now();
        return {bus.vl_sel, bus.vtype_sel, bus.lumop_sel};
    endfunction

    task automatic sb_push(input ev_kind_t k, input logic [31:0] inst, input logic [2:0] sel);
        ev_t e;
        e.kind = k;
        e.inst = inst;
        e.sel  = sel;
        sb.push_back(e);
    endtask

    task automatic observe(input ev_kind_t k);
        ev_t want;
        if (sb.size() == 0) begin
            check("sb_spurious", 32'(k), 32'(EV_NONE));
        end else begin
            want = sb.pop_front();
            check("sb_kind", 32'(k), 32'(want.kind));
            check("sb_inst_q", bus.inst_q, want.inst);
            check("sb_sel", 32'(sel_now()), 32'(want.sel));
        end
    endtask

    always @(posedge clk) begin
        #4;
        if (bus.csr_wr_en) observe(EV_CSR);
        if (bus.issue_valid && bus.issue_ready) observe(EV_ISSUE);
        if (bus.illegal) observe(EV_ILLEGAL);
        if (bus.timeout) observe(EV_TIMEOUT);
    end

    task automatic adv();
        @(posedge clk);
        #2;
    endtask

    task automatic run_inst(input vec_t v);
        int last;
        logic [2:0] sel;
        sel = {v.vl, v.vtype, v.lumop};
        for (int n = 0; n < 20 && !bus.inst_ready; n++) adv();
        check("accept_ready", 32'(bus.inst_ready), 32'd1);
        sb_push(v.kind, v.inst, sel);
        if (v.exp_to) sb_push(EV_TIMEOUT, v.inst, sel);
        bus.inst_valid  = 1'b1;
        bus.vec_inst    = v.inst;
        bus.is_vec      = 1'b0;
        bus.issue_ready = 1'b0;
        bus.exe_done    = 1'b0;
        adv();
        bus.inst_valid = 1'b0;
        bus.vec_inst   = $urandom();
        bus.is_vec     = v.is_vec;
        #1;
        check("decode_ready_busy", 32'({bus.inst_ready, bus.vec_busy}), 32'b01);
        check("decode_inst_q", bus.inst_q, v.inst);
        check("decode_sel", 32'(sel_now()), 32'(sel));
        check("decode_illegal", 32'(bus.illegal), 32'(v.kind == EV_ILLEGAL));
        adv();
        bus.is_vec = 1'b0;
        if (v.kind == EV_ILLEGAL) begin
            #1;
            check("illegal_idle", 32'({bus.inst_ready, bus.vec_busy, bus.illegal}), 32'b100);
        end else if (v.kind == EV_CSR) begin
            #1;
            check("config_strobe",
                  32'({bus.csr_wr_en, bus.issue_valid, bus.inst_ready, bus.vec_busy}), 32'b1001);
            check("config_sel", 32'(sel_now()), 32'(sel));
            adv();
            #1;
            check("config_done", 32'({bus.csr_wr_en, bus.inst_ready, bus.vec_busy}), 32'b010);
        end else begin
            for (int k = 0; k <= v.issue_wait; k++) begin
                if (k > 0) adv();
                bus.issue_ready = (k == v.issue_wait);
                bus.exe_done    = (k == v.issue_wait) && (v.exe_delay == 0);
                #1;
                check("issue_valid", 32'({bus.issue_valid, bus.inst_ready}), 32'b10);
                check("issue_inst_q", bus.inst_q, v.inst);
                check("issue_lumop", 32'(bus.lumop_sel), 32'(v.lumop));
            end
            last = (v.exe_delay == 0) ? 0 : (v.exp_to ? TO_CYC : v.exe_delay);
            for (int d = 1; d <= last; d++) begin
                adv();
                bus.issue_ready = 1'b0;
                bus.exe_done    = (d == v.exe_delay);
                #1;
                check("wait_state", 32'({bus.issue_valid, bus.inst_ready, bus.vec_busy}), 32'b001);
                check("wait_lumop", 32'(bus.lumop_sel), 32'(v.lumop));
                check("wait_timeout", 32'(bus.timeout), 32'(v.exp_to && (d == last)));
            end
            adv();
            bus.issue_ready = 1'b0;
            bus.exe_done    = 1'b0;
            #1;
            check("issue_done",
                  32'({bus.inst_ready, bus.vec_busy, bus.issue_valid, bus.timeout}), 32'b1000);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        n_vec  = 0;
        n_fail = 0;
        //              inst          vec  iw  exe  kind        vl    vt    lu    to
        vecs[0]  = '{32'h010572D7, 1'b1, 0,  0, EV_CSR,     1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{32'hC10272D7, 1'b1, 0,  0, EV_CSR,     1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{32'h80C572D7, 1'b1, 0,  0, EV_CSR,     1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'h022180D7, 1'b1, 3,  2, EV_ISSUE,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'h02056207, 1'b1, 0,  1, EV_ISSUE,   1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{32'h00000013, 1'b0, 0,  0, EV_ILLEGAL, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h02056227, 1'b1, 1,  0, EV_ISSUE,   1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{32'h0A056207, 1'b1, 0,  3, EV_ISSUE,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'h02056207, 1'b1, 0, -1, EV_ISSUE,   1'b0, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{32'h022180D7, 1'b1, 0,  4, EV_ISSUE,   1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{32'h022180D7, 1'b1, 2, -1, EV_ISSUE,   1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{32'h010572D7, 1'b0, 0,  0, EV_ILLEGAL, 1'b0, 1'b1, 1'b0, 1'b0};

        reset           = 1'b1;
        bus.inst_valid  = 1'b0;
        bus.vec_inst    = '0;
        bus.is_vec      = 1'b0;
        bus.issue_ready = 1'b0;
        bus.exe_done    = 1'b0;
        adv();
        adv();
        #1;
        check("reset_ready", 32'(bus.inst_ready), 32'd1);
        check("reset_outs", 32'({bus.csr_wr_en, bus.issue_valid, bus.vec_busy, bus.illegal,
                                 bus.timeout, sel_now()}), 32'd0);
        check("reset_inst_q", bus.inst_q, 32'd0);
        reset = 1'b0;
        adv();

        for (int i = 0; i < NV; i++) run_inst(vecs[i]);

        // Back-to-back: inst_valid held high; exe_done outside ISSUE/WAIT ignored.
        sb_push(EV_ISSUE, 32'h022180D7, 3'b000);
        bus.inst_valid = 1'b1;
        bus.vec_inst   = 32'h022180D7;
        bus.exe_done   = 1'b1;
        adv();
        bus.vec_inst = 32'hC10272D7;
        bus.is_vec   = 1'b1;
        #1;
        check("b2b_decode_inst_q", bus.inst_q, 32'h022180D7);
        adv();
        bus.is_vec      = 1'b0;
        bus.exe_done    = 1'b0;
        bus.issue_ready = 1'b1;
        #1;
        check("b2b_issue", 32'({bus.issue_valid, bus.csr_wr_en}), 32'b10);
        adv();
        bus.issue_ready = 1'b0;
        bus.exe_done    = 1'b1;
        #1;
        check("b2b_wait_not_ready", 32'(bus.inst_ready), 32'd0);
        check("b2b_wait_inst_q", bus.inst_q, 32'h022180D7);
        adv();
        bus.exe_done = 1'b0;
        sb_push(EV_CSR, 32'hC10272D7, 3'b110);
        #1;
        check("b2b_idle_ready", 32'(bus.inst_ready), 32'd1);
        check("b2b_idle_inst_q", bus.inst_q, 32'h022180D7);
        adv();
        bus.inst_valid = 1'b0;
        bus.is_vec     = 1'b1;
        #1;
        check("b2b_second_inst_q", bus.inst_q, 32'hC10272D7);
        adv();
        bus.is_vec = 1'b0;
        #1;
        check("b2b_second_csr", 32'(bus.csr_wr_en), 32'd1);
        adv();
        #1;
        check("b2b_second_idle", 32'(bus.inst_ready), 32'd1);

        // Reset on the cycle the watchdog would fire.
        sb_push(EV_ISSUE, 32'h022180D7, 3'b000);
        bus.inst_valid = 1'b1;
        bus.vec_inst   = 32'h022180D7;
        adv();
        bus.inst_valid = 1'b0;
        bus.is_vec     = 1'b1;
        adv();
        bus.is_vec      = 1'b0;
        bus.issue_ready = 1'b1;
        adv();
        bus.issue_ready = 1'b0;
        for (int w = 2; w <= TO_CYC; w++) begin
            adv();
            if (w == TO_CYC) reset = 1'b1;
            #1;
            check("rst_wait_no_timeout", 32'({bus.timeout, bus.issue_valid}), 32'b00);
        end
        adv();
        reset = 1'b0;
        #1;
        check("rst_wait_idle", 32'({bus.inst_ready, bus.vec_busy, bus.issue_valid}), 32'b100);
        check("rst_wait_inst_q", bus.inst_q, 32'd0);
        adv();
        #1;
        check("rst_wait_quiet", 32'({bus.timeout, bus.csr_wr_en, bus.vec_busy}), 32'b000);

        // Reset during CONFIG suppresses the CSR strobe.
        bus.inst_valid = 1'b1;
        bus.vec_inst   = 32'h010572D7;
        adv();
        bus.inst_valid = 1'b0;
        bus.is_vec     = 1'b1;
        adv();
        bus.is_vec = 1'b0;
        reset      = 1'b1;
        #1;
        check("rst_config_no_csr", 32'(bus.csr_wr_en), 32'd0);
        adv();
        reset = 1'b0;
        #1;
        check("rst_config_idle", 32'({bus.inst_ready, bus.vec_busy, bus.csr_wr_en}), 32'b100);
        check("rst_config_inst_q", bus.inst_q, 32'd0);
        adv();
        adv();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
